// File: rtl/vga_pkg.sv
// Shared timing defaults, colour-source modes and colour helpers for the VGA scan engine.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam bit          DEF_SYNC_POL = 1'b0;
    localparam int unsigned DEF_RD_LAT   = 1;
    localparam int unsigned DEF_CW       = 10;

    typedef enum logic [1:0] {
        SRC_PIX   = 2'd0,
        SRC_SOLID = 2'd1,
        SRC_BARS  = 2'd2,
        SRC_GRID  = 2'd3
    } src_mode_e;

    // Bar k occupies byte k, so bar 0 sits in the least significant byte.
    localparam logic [63:0] BAR_TABLE = {8'h00, 8'h03, 8'hE0, 8'hE3,
                                         8'h1C, 8'h1F, 8'hFC, 8'hFF};

    // Per-pixel control word carried through the read-latency delay line.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       ls;
        logic       use_pix;
        logic [7:0] color;
    } scan_ctl_t;

    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        return BAR_TABLE[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [11:0] expand_rgb332(input logic [7:0] c);
        return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
    endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// Pixel fetch bus between the scan engine (master) and the frame-buffer source (slave).
interface vga_scan_engine_if #(
    parameter int unsigned CW = 10
);
    logic          req;
    logic [CW-1:0] req_h;
    logic [CW-1:0] req_v;
    logic [7:0]    pix_data;

    modport master (output req, output req_h, output req_v, input pix_data);
    modport slave  (input req, input req_h, input req_v, output pix_data);
endinterface

// File: rtl/vga_delay_line.sv
// Enabled shift register with synchronous clear; DEPTH stages of W bits.
module vga_delay_line #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clr) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_engine.sv
// VGA timing generator with pixel fetch, generated test patterns and
// latency-aligned sync/colour outputs.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL,
    parameter int unsigned RD_LAT   = DEF_RD_LAT,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [7:0]        solid_color,
    vga_scan_engine_if.master pix_if,
    output logic [CW-1:0]     hc_out,
    output logic [CW-1:0]     vc_out,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              frame_start,
    output logic              line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);

    if ((H_ACTIVE % 8) != 0) begin : g_bad_h_active
        $error("vga_scan_engine: H_ACTIVE must be a multiple of 8");
    end
    if ((H_TOTAL > (32'd1 << CW)) || (V_TOTAL > (32'd1 << CW))) begin : g_bad_cw
        $error("vga_scan_engine: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
        $error("vga_scan_engine: RD_LAT must be in 1..4");
    end

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    src_mode_e     mode_q, mode_d;
    src_mode_e     cur_mode;
    logic          at_origin;
    logic          req_c;
    logic [2:0]    bar_idx;
    scan_ctl_t     raw_ctl;
    scan_ctl_t     pipe_ctl;

    assign at_origin = (hc_q == '0) && (vc_q == '0);
    assign req_c     = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    // The frame's first pixel already uses the mode being latched at the origin.
    assign cur_mode  = at_origin ? src_mode_e'(mode) : mode_q;

    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        mode_d = mode_q;
        if (en) begin
            if (hc_q == H_LAST_C) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST_C) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
            if (at_origin) begin
                mode_d = src_mode_e'(mode);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hc_q   <= '0;
            vc_q   <= '0;
            mode_q <= SRC_PIX;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            mode_q <= mode_d;
        end
    end

    assign pix_if.req   = req_c;
    assign pix_if.req_h = req_c ? hc_q : '0;
    assign pix_if.req_v = req_c ? vc_q : '0;
    assign hc_out       = hc_q;
    assign vc_out       = vc_q;

    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (hc_q >= CW'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end

        raw_ctl.hs      = (hc_q >= HS_BEG_C) && (hc_q < HS_END_C);
        raw_ctl.vs      = (vc_q >= VS_BEG_C) && (vc_q < VS_END_C);
        raw_ctl.de      = req_c;
        raw_ctl.fs      = at_origin;
        raw_ctl.ls      = (hc_q == '0) && (vc_q < V_ACT_C);
        raw_ctl.use_pix = 1'b0;
        raw_ctl.color   = '0;
        case (cur_mode)
            SRC_PIX:   raw_ctl.use_pix = 1'b1;
            SRC_SOLID: raw_ctl.color   = solid_color;
            SRC_BARS:  raw_ctl.color   = bar_color(bar_idx);
            SRC_GRID:  raw_ctl.color   = ((hc_q[4:0] == '0) || (vc_q[4:0] == '0)) ? 8'hFF : 8'h00;
            default:   raw_ctl.color   = '0;
        endcase
    end

    vga_delay_line #(
        .W     ($bits(scan_ctl_t)),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk (clk),
        .en  (en),
        .clr (~rst),
        .d   (raw_ctl),
        .q   (pipe_ctl)
    );

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic        ls_q, ls_d;
    logic [11:0] rgb_q, rgb_d;
    logic [7:0]  src_color;

    // Delay-line output meets pix_data RD_LAT cycles after its request.
    always_comb begin
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        de_d      = de_q;
        fs_d      = fs_q;
        ls_d      = ls_q;
        rgb_d     = rgb_q;
        src_color = pipe_ctl.use_pix ? pix_if.pix_data : pipe_ctl.color;
        if (en) begin
            hsync_d = pipe_ctl.hs ? SYNC_POL : ~SYNC_POL;
            vsync_d = pipe_ctl.vs ? SYNC_POL : ~SYNC_POL;
            de_d    = pipe_ctl.de;
            fs_d    = pipe_ctl.fs;
            ls_d    = pipe_ctl.ls;
            rgb_d   = pipe_ctl.de ? expand_rgb332(src_color) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench: a default-timing instance (A) and a small-timing, RD_LAT=3,
// positive-sync instance (B), each checked against hand-computed cycle values.
module tb_vga_scan_engine;

    logic       clk;
    logic       rst_a, en_a, rst_b, en_b;
    logic [1:0] mode_a, mode_b;
    logic [7:0] solid;

    logic [9:0] hc_a, vc_a, hc_b, vc_b;
    logic       hs_a, vs_a, de_a, fs_a, ls_a;
    logic       hs_b, vs_b, de_b, fs_b, ls_b;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int vectors;
    int miscompares;
    int cyc;

    vga_scan_engine_if #(.CW(10)) if_a ();
    vga_scan_engine_if #(.CW(10)) if_b ();

    vga_scan_engine dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .solid_color(solid),
        .pix_if(if_a.master), .hc_out(hc_a), .vc_out(vc_a), .hsync(hs_a), .vsync(vs_a),
        .de(de_a), .red(r_a), .green(g_a), .blue(b_a),
        .frame_start(fs_a), .line_start(ls_a)
    );

    vga_scan_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .RD_LAT(3), .CW(10)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .solid_color(solid),
        .pix_if(if_b.master), .hc_out(hc_b), .vc_out(vc_b), .hsync(hs_b), .vsync(vs_b),
        .de(de_b), .red(r_b), .green(g_b), .blue(b_b),
        .frame_start(fs_b), .line_start(ls_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst_a = 1'b0; en_a = 1'b1; mode_a = 2'd0;
        rst_b = 1'b0; en_b = 1'b1; mode_b = 2'd0;
        solid = 8'h1C;
        if_a.pix_data = 8'hE4;
        if_b.pix_data = 8'h00;

        // ---------------- instance A: defaults ----------------
        repeat (3) tick();
        chk("a_rst_hc", hc_a, 0);
        chk("a_rst_vc", vc_a, 0);
        chk("a_rst_hsync", hs_a, 1);
        chk("a_rst_vsync", vs_a, 1);
        chk("a_rst_de", de_a, 0);
        chk("a_rst_fs", fs_a, 0);
        chk("a_rst_red", r_a, 0);

        rst_a = 1'b1; cyc = 0;
        chk("a_c0_req", if_a.req, 1);
        chk("a_c0_req_h", if_a.req_h, 0);
        chk("a_c0_req_v", if_a.req_v, 0);
        chk("a_c0_de", de_a, 0);
        goto(1);
        chk("a_c1_de", de_a, 0);
        chk("a_c1_fs", fs_a, 0);
        chk("a_c1_hc", hc_a, 1);
        goto(2);
        chk("a_c2_de", de_a, 1);
        chk("a_c2_fs", fs_a, 1);
        chk("a_c2_ls", ls_a, 1);
        chk("a_c2_red", r_a, 4'hF);
        chk("a_c2_green", g_a, 4'h2);
        chk("a_c2_blue", b_a, 4'h0);
        goto(3);
        chk("a_c3_fs", fs_a, 0);
        chk("a_c3_ls", ls_a, 0);
        goto(639);
        chk("a_req_h_639", if_a.req_h, 639);
        goto(640);
        chk("a_req_640", if_a.req, 0);
        chk("a_req_h_640", if_a.req_h, 0);
        goto(641);
        chk("a_de_col639", de_a, 1);
        goto(642);
        chk("a_de_blank", de_a, 0);
        chk("a_red_blank", r_a, 0);
        chk("a_green_blank", g_a, 0);
        goto(657);
        chk("a_hsync_657", hs_a, 1);
        goto(658);
        chk("a_hsync_658", hs_a, 0);
        goto(753);
        chk("a_hsync_753", hs_a, 0);
        goto(754);
        chk("a_hsync_754", hs_a, 1);
        goto(800);
        chk("a_wrap_hc", hc_a, 0);
        chk("a_wrap_vc", vc_a, 1);
        goto(801);
        chk("a_ls_801", ls_a, 0);
        goto(802);
        chk("a_ls_802", ls_a, 1);
        chk("a_fs_802", fs_a, 0);

        goto(900);
        chk("a_hc_900", hc_a, 100);
        en_a = 1'b0; if_a.pix_data = 8'h00;
        goto(910);
        chk("a_frz_hc", hc_a, 100);
        chk("a_frz_vc", vc_a, 1);
        chk("a_frz_de", de_a, 1);
        chk("a_frz_red", r_a, 4'hF);
        chk("a_frz_green", g_a, 4'h2);
        en_a = 1'b1; if_a.pix_data = 8'hE4;
        goto(911);
        chk("a_resume_hc", hc_a, 101);
        chk("a_resume_red", r_a, 4'hF);
        goto(1467);
        chk("a_hsync_1467", hs_a, 1);
        goto(1468);
        chk("a_hsync_1468", hs_a, 0);

        // mid-frame reset, restarting in bars mode
        goto(1500);
        rst_a = 1'b0; mode_a = 2'd2;
        tick();
        chk("a_mrst_hc", hc_a, 0);
        chk("a_mrst_vc", vc_a, 0);
        chk("a_mrst_de", de_a, 0);
        chk("a_mrst_hsync", hs_a, 1);
        chk("a_mrst_red", r_a, 0);
        rst_a = 1'b1; cyc = 0;
        chk("a_mrst_req", if_a.req, 1);
        goto(1);
        chk("a_mrst_c1_de", de_a, 0);
        chk("a_mrst_c1_fs", fs_a, 0);
        goto(2);
        chk("a_bars_fs", fs_a, 1);
        chk("a_bars_c0_blue", b_a, 4'hF);
        goto(81);
        chk("a_bars_c79_blue", b_a, 4'hF);
        goto(82);
        chk("a_bars_c80_red", r_a, 4'hF);
        chk("a_bars_c80_green", g_a, 4'hF);
        chk("a_bars_c80_blue", b_a, 4'h0);
        goto(641);
        chk("a_bars_c639_de", de_a, 1);
        chk("a_bars_c639_rgb", {r_a, g_a, b_a}, 12'h000);

        // solid fill after another reset
        rst_a = 1'b0; mode_a = 2'd1;
        tick();
        rst_a = 1'b1; cyc = 0;
        goto(2);
        chk("a_solid_rgb", {r_a, g_a, b_a}, 12'h0F0);

        // ---------------- instance B: small timing, RD_LAT=3 ----------------
        rst_a = 1'b0;
        tick();
        chk("b_rst_hsync", hs_b, 0);
        chk("b_rst_vsync", vs_b, 0);
        chk("b_rst_de", de_b, 0);
        rst_b = 1'b1; cyc = 0;
        chk("b_c0_req", if_b.req, 1);
        goto(3);
        chk("b_c3_de", de_b, 0);
        if_b.pix_data = 8'h6D;
        goto(4);
        if_b.pix_data = 8'h00;
        chk("b_c4_de", de_b, 1);
        chk("b_c4_fs", fs_b, 1);
        chk("b_lat_rgb", {r_b, g_b, b_b}, 12'h665);
        goto(5);
        chk("b_c5_rgb", {r_b, g_b, b_b}, 12'h000);
        goto(19);
        chk("b_de_col15", de_b, 1);
        goto(20);
        chk("b_de_col16", de_b, 0);
        goto(21);
        chk("b_hsync_21", hs_b, 0);
        goto(22);
        chk("b_hsync_22", hs_b, 1);
        goto(25);
        chk("b_hsync_25", hs_b, 1);
        goto(26);
        chk("b_hsync_26", hs_b, 0);
        goto(50);
        mode_b = 2'd2;
        goto(76);
        chk("b_midswitch_de", de_b, 1);
        chk("b_midswitch_red", r_b, 0);
        goto(219);
        chk("b_vsync_219", vs_b, 0);
        goto(220);
        chk("b_vsync_220", vs_b, 1);
        goto(267);
        chk("b_vsync_267", vs_b, 1);
        goto(268);
        chk("b_vsync_268", vs_b, 0);
        goto(291);
        chk("b_fs_291", fs_b, 0);
        goto(292);
        chk("b_fs_292", fs_b, 1);
        chk("b_bars_c0", {r_b, g_b, b_b}, 12'hFFF);
        goto(294);
        chk("b_bars_c2", {r_b, g_b, b_b}, 12'hFF0);
        goto(307);
        chk("b_bars_c15", {r_b, g_b, b_b}, 12'h000);
        goto(390);
        mode_b = 2'd3;
        goto(415);
        chk("b_bars_hold", {r_b, g_b, b_b}, 12'hFF0);
        goto(580);
        chk("b_grid_fs", fs_b, 1);
        chk("b_grid_00", {r_b, g_b, b_b}, 12'hFFF);
        goto(604);
        chk("b_grid_01", {r_b, g_b, b_b}, 12'hFFF);
        goto(605);
        chk("b_grid_11_de", de_b, 1);
        chk("b_grid_11", {r_b, g_b, b_b}, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; SYNC_POL 0 asserted sync level; RD_LAT 1 pixel-source read latency, legal 1..4; CW 10 counter width.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 pixel clock; rst in 1 reset; en in 1 scan advance enable; mode in 2 source select; solid_color in 8 RGB332 fill colour; pix_data in 8 RGB332 pixel from the frame buffer; req out 1 pixel request; req_h out CW requested column; req_v out CW requested row; hc_out out CW horizontal counter; vc_out out CW vertical counter; hsync out 1; vsync out 1; de out 1 display enable; red out 4; green out 4; blue out 4; frame_start out 1; line_start out 1.
REQ-003 One clock; reset is synchronous and active-low.

Function
REQ-004 hc_out SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP) and wrap to 0; vc_out SHALL increment only on hc_out wrap, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-005 While en=0, counters, pipeline and all outputs SHALL hold their values.
REQ-006 req SHALL be combinationally high when hc_out<H_ACTIVE and vc_out<V_ACTIVE; req_h=hc_out, req_v=vc_out whenever req=1, else 0.
REQ-007 pix_data SHALL be sampled exactly RD_LAT enabled cycles after the corresponding req.
REQ-008 Raw hsync SHALL be asserted (level SYNC_POL) for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); raw vsync for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) over whole lines; raw de = req.
REQ-009 hsync, vsync, de, frame_start, line_start and colour outputs SHALL be registered and delayed RD_LAT+1 cycles from the counter state that produced them, so all are mutually aligned.
REQ-010 Colour expansion SHALL be: red={c[7:5],c[7]}, green={c[4:2],c[4]}, blue={c[1:0],c[1:0]}; when de=0 all colour outputs SHALL be 0.
REQ-011 mode SHALL select the colour source: 0 pix_data; 1 solid_color; 2 eight vertical colour bars, bar k covering hc in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8), colours in order FF,FC,1F,1C,E3,E0,03,00 (RGB332); 3 grid, FF where hc[4:0]==0 or vc[4:0]==0, else 00.
REQ-012 Generated modes (1..3) SHALL use the same RD_LAT+1 alignment as mode 0.
REQ-013 mode SHALL be latched only when hc_out=0 and vc_out=0 with en=1; changes mid-frame take effect from the next frame.
REQ-014 frame_start SHALL pulse one cycle, coincident with de of pixel (0,0); line_start SHALL pulse one cycle coincident with de of column 0 of every visible line.
REQ-015 H_ACTIVE SHALL be a multiple of 8; H_TOTAL and V_TOTAL SHALL fit in CW bits (elaboration check).

Reset
REQ-016 On rst=0 at a clk edge: hc_out=0, vc_out=0, hsync=vsync=~SYNC_POL, de=0, frame_start=line_start=0, colours=0, delay pipeline cleared, latched mode=0.
REQ-017 Reset mid-frame SHALL restart scanning at (0,0) on the first enabled cycle after release; no partial-pipeline pixels SHALL appear on outputs.

Structure
REQ-018 Package vga_pkg SHALL hold default timing constants, the mode enumeration (SRC_PIX, SRC_SOLID, SRC_BARS, SRC_GRID) and the bar colour table.
REQ-019 One sub-module vga_delay_line (parametrised width and depth shift register with enable and synchronous clear) SHALL align sync/de/pulse/colour-control signals.

Verification
REQ-020 Defaults, release rst with en=1 -> req=1 with req_h=0,req_v=0 in cycle 0; de, frame_start first high in cycle 2.
REQ-021 Defaults -> hsync low for 96 clocks starting hc=656 delayed by 2; line period 800 clocks; vsync low during lines 490-491; frame period 420000 clocks.
REQ-022 mode=0, pix_data=8'hE4 -> red=F, green=2, blue=0; same pix_data during blanking -> all colours 0.
REQ-023 mode=2 -> pixel at column 80 shows red=F,green=F,blue=0; column 639 shows 0,0,0; mode switched to 3 at line 100 -> bars continue until next frame_start, grid thereafter.
REQ-024 RD_LAT=3 -> de and colours lag req by 4 cycles; pix_data value presented 3 cycles after req appears on outputs.
REQ-025 en low for 10 cycles mid-line -> all outputs frozen, timing resumes without lost or duplicated pixels; rst pulsed at line 200 -> outputs at reset values, next frame_start exactly 2 cycles after release.
